rs422_frame_reader: RTL and testbench

RS422_FRAME_READER -- requirements
Module: rs422_frame_reader

---
 rtl/rs422_frame_reader_if.sv | 33 +++
 rtl/rs422_frame_reader.sv | 191 +++++++++++++++++++
 tb/tb_rs422_frame_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs422_frame_reader_if.sv
// Bus bundle between the frame reader and its FIFO and UART transmitter.
// master: the frame reader (issues FIFO reads, offers tx bytes).
// slave : the FIFO/UART side (supplies occupancy and read data, accepts tx bytes).
//   fifo_usedw  FIFO occupancy (PTRWIDTH+1 bits)
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid with fifo_valid
//   fifo_valid  read-data strobe, one cycle after an accepted fifo_load
//   fifo_load   one-cycle FIFO read request
//   tx_ready    transmitter can take a byte
//   tx_data     byte offered to the transmitter
//   tx_valid    byte offered; transfer when tx_valid && tx_ready
interface rs422_frame_reader_if #(
  parameter int unsigned PTRWIDTH = 9
);
  logic [PTRWIDTH:0] fifo_usedw;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;
  logic              fifo_valid;
  logic              fifo_load;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;

  modport master (
    input  fifo_usedw, fifo_empty, fifo_dout, fifo_valid, tx_ready,
    output fifo_load, tx_data, tx_valid
  );

  modport slave (
    output fifo_usedw, fifo_empty, fifo_dout, fifo_valid, tx_ready,
    input  fifo_load, tx_data, tx_valid
  );
endinterface

// File: rtl/rs422_frame_reader.sv
// Drains a byte FIFO into framed RS-422 packets: HDR0, HDR1, LEN, payload, CSUM.
// A frame starts once MAX_LEN bytes are queued, or after TIMEOUT idle cycles
// with a partial FIFO. CSUM is the modulo-256 sum of LEN and the payload.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   bus         master side of rs422_frame_reader_if (FIFO read + UART tx)
//   busy        high whenever the reader is not idle
//   frame_done  one-cycle pulse after the checksum byte is accepted
module rs422_frame_reader #(
  parameter int unsigned PTRWIDTH = 9,
  parameter logic [7:0]  HDR0     = 8'hEB,
  parameter logic [7:0]  HDR1     = 8'h90,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned TIMEOUT  = 5000
) (
  input  logic                clk,
  input  logic                rst,
  rs422_frame_reader_if.master bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned UW = PTRWIDTH + 1;
  localparam logic [UW-1:0] MAX_LEN_W = UW'(MAX_LEN);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0]   TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, S_HDR0, S_HDR1, S_LEN, FETCH, WAIT_DATA, SEND_DATA, S_CSUM, DONE
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] idle_q, idle_n;
  logic [7:0]  len_q, len_n;
  logic [7:0]  csum_q, csum_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [7:0]  cnt_inc;
  logic [7:0]  tx_data_q, tx_data_n;
  logic        tx_valid_q, tx_valid_n;
  logic        load_q, load_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        start_c;
  logic        accept_c;

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.fifo_load = load_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

  assign start_c  = (bus.fifo_usedw >= MAX_LEN_W) ||
                    ((idle_q == TIMEOUT_W) && !bus.fifo_empty);
  assign accept_c = tx_valid_q && bus.tx_ready;
  assign cnt_inc  = cnt_q + 8'd1;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idle_q     <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      idle_q     <= idle_n;
      len_q      <= len_n;
      csum_q     <= csum_n;
      cnt_q      <= cnt_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      load_q     <= load_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  // Next state and next output values. Outputs are registered alongside the
  // state, so each branch sets what the outputs must show in the next state.
  always_comb begin
    state_n    = state_q;
    idle_n     = '0;
    len_n      = len_q;
    csum_n     = csum_q;
    cnt_n      = cnt_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = 1'b0;
    load_n     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_n    = S_HDR0;
          len_n      = (bus.fifo_usedw >= MAX_LEN_W) ? MAX_LEN_B : 8'(bus.fifo_usedw);
          csum_n     = '0;
          cnt_n      = '0;
          tx_valid_n = 1'b1;
          tx_data_n  = HDR0;
        end else if (!bus.fifo_empty && (bus.fifo_usedw < MAX_LEN_W)) begin
          idle_n = idle_q + 16'd1;
        end
      end

      S_HDR0: begin
        tx_valid_n = 1'b1;
        if (accept_c) begin
          state_n   = S_HDR1;
          tx_data_n = HDR1;
        end
      end

      S_HDR1: begin
        tx_valid_n = 1'b1;
        if (accept_c) begin
          state_n   = S_LEN;
          tx_data_n = len_q;
        end
      end

      S_LEN: begin
        tx_valid_n = 1'b1;
        if (accept_c) begin
          state_n    = FETCH;
          tx_valid_n = 1'b0;
          csum_n     = csum_q + len_q;
          load_n     = !bus.fifo_empty;
        end
      end

      // The read request is raised on entry when data is already present;
      // otherwise it is raised once the FIFO reports data.
      FETCH: begin
        if (load_q) begin
          state_n = WAIT_DATA;
        end else begin
          load_n = !bus.fifo_empty;
        end
      end

      WAIT_DATA: begin
        if (bus.fifo_valid) begin
          state_n    = SEND_DATA;
          csum_n     = csum_q + bus.fifo_dout;
          tx_data_n  = bus.fifo_dout;
          tx_valid_n = 1'b1;
        end
      end

      SEND_DATA: begin
        tx_valid_n = 1'b1;
        if (accept_c) begin
          cnt_n = cnt_inc;
          if (cnt_inc == len_q) begin
            state_n   = S_CSUM;
            tx_data_n = csum_q;
          end else begin
            state_n    = FETCH;
            tx_valid_n = 1'b0;
            load_n     = !bus.fifo_empty;
          end
        end
      end

      S_CSUM: begin
        tx_valid_n = 1'b1;
        if (accept_c) begin
          state_n    = DONE;
          tx_valid_n = 1'b0;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_rs422_frame_reader.sv
// Directed bench for rs422_frame_reader with a behavioural FIFO and UART sink.
module tb_rs422_frame_reader;

  localparam int unsigned PTRWIDTH = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic frame_done;
  logic rdy = 1'b1;
  logic bp_en = 1'b0;
  int   bp_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  rs422_frame_reader_if #(.PTRWIDTH(PTRWIDTH)) bus ();

  rs422_frame_reader #(.PTRWIDTH(PTRWIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: one-cycle read latency
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.fifo_usedw = 10'(wr_ptr - rd_ptr);
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.tx_ready   = rdy;

  always @(posedge clk) begin
    bus.fifo_valid <= 1'b0;
    if (bus.fifo_load && (wr_ptr != rd_ptr)) begin
      bus.fifo_dout  <= mem[rd_ptr[9:0]];
      bus.fifo_valid <= 1'b1;
      rd_ptr         <= rd_ptr + 1;
    end
  end

  // tx_ready: constant 1, or toggling every 3 cycles under backpressure
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bp_cnt = bp_cnt + 1;
      if (bp_cnt == 3) begin
        bp_cnt = 0;
        rdy    = ~rdy;
      end
    end else begin
      bp_cnt = 0;
      rdy    = 1'b1;
    end
  end

  // Sink / monitor, sampled mid-cycle
  logic [7:0] rx [$];
  int         done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      pend       = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.tx_valid), 32'd1);
        check("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.fifo_valid) pend = 1'b0;
      if (bus.fifo_load) begin
        check("load_nonempty", 32'(bus.fifo_empty), 32'd0);
        check("load_single", 32'(pend), 32'd0);
        pend = 1'b1;
      end
      if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
      if (frame_done) done_cnt++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bytes(input int n, input logic [7:0] first, input logic [7:0] stp);
    for (int i = 0; i < n; i++) mem[10'(wr_ptr + i)] = 8'(first + 8'(stp * 8'(i)));
    wr_ptr = wr_ptr + n;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while ((done_cnt == start) && (n < budget)) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while ((rx.size() < cnt) && (n < budget)) begin
      step();
      n++;
    end
    check({tag, "_rx_reached"}, 32'(rx.size() >= cnt), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input int len, input int csum_exp);
    logic [7:0] exp [$];
    logic [7:0] sum;
    exp.push_back(8'hEB);
    exp.push_back(8'h90);
    exp.push_back(8'(len));
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      exp.push_back(mem[10'(base + i)]);
      sum = sum + mem[10'(base + i)];
    end
    exp.push_back(sum);
    check({tag, "_size"}, 32'(rx.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    if (csum_exp >= 0)
      check({tag, "_csum"}, (rx.size() > 0) ? 32'(rx[rx.size()-1]) : 32'hFFFF_FFFF,
            32'(csum_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_load"}, 32'(bus.fifo_load), 32'd0);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int n;
    int d0;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) step();

    // Threshold frame: 64 bytes 0x01..0x40
    write_bytes(64, 8'h01, 8'h01);
    wait_done("t1", 1000);
    check_frame("t1", 0, 64, 'h60);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_usedw", 32'(bus.fifo_usedw), 32'd0);
    step();
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Timeout flush: 10 20 30
    rx.delete();
    repeat (2) step();
    write_bytes(3, 8'h10, 8'h10);
    n = 0;
    while (!busy && (n < 6000)) begin
      step();
      n++;
    end
    check("t2_start_cycles", 32'(n), 32'd5001);
    wait_done("t2", 200);
    check_frame("t2", 64, 3, 'h63);

    // Backpressure on a 4-byte frame: A1 B2 C3 D4, CSUM EE
    rx.delete();
    repeat (2) step();
    bp_en = 1'b1;
    write_bytes(4, 8'hA1, 8'h11);
    wait_done("t3", 7000);
    bp_en = 1'b0;
    check_frame("t3", 67, 4, 'hEE);

    // Overfill: 100 bytes -> LEN 0x40 then LEN 0x24
    rx.delete();
    repeat (4) step();
    write_bytes(100, 8'h05, 8'h03);
    wait_done("t4a", 1000);
    check_frame("t4a", 71, 64, -1);
    rx.delete();
    wait_done("t4b", 7000);
    check_frame("t4b", 135, 36, -1);
    check("t4_usedw", 32'(bus.fifo_usedw), 32'd0);

    // Writes during a frame do not change LEN
    rx.delete();
    repeat (4) step();
    write_bytes(64, 8'h80, 8'h01);
    wait_rx("t5", 10, 200);
    write_bytes(10, 8'h40, 8'h07);
    wait_done("t5a", 1000);
    check_frame("t5a", 171, 64, -1);
    rx.delete();
    wait_done("t5b", 7000);
    check_frame("t5b", 235, 10, -1);

    // Reset during payload byte 5
    rx.delete();
    repeat (4) step();
    write_bytes(64, 8'h33, 8'h01);
    wait_rx("t6", 7, 200);
    n = 0;
    while (!bus.tx_valid && (n < 20)) begin
      step();
      n++;
    end
    check("t6_byte5_offered", 32'(bus.tx_valid), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    repeat (3) step();
    rst = 1'b0;
    repeat (50) step();
    check("t6_no_done", 32'(done_cnt), 32'(d0));
    check("t6_rx_cnt", 32'(rx.size()), 32'd7);
    check("t6_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
